// File: rtl/ir_beacon_tx_pkg.sv
// ir_beacon_tx shared types, default tone half-periods
// and the freq_sel to half-period lookup.
package ir_beacon_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONE,
    S_GAP
  } bcn_state_e;

  localparam int DEF_HALF0 = 50000;
  localparam int DEF_HALF1 = 5000;
  localparam int DEF_HALF2 = 500;
  localparam int DEF_HALF3 = 50;
  localparam int DEF_CNT_W = 16;

  function automatic int half_of(
    input logic [1:0] sel,
    input int         h0,
    input int         h1,
    input int         h2,
    input int         h3
  );
    int h;
    h = h0;
    unique case (sel)
      2'd0: h = h0;
      2'd1: h = h1;
      2'd2: h = h2;
      2'd3: h = h3;
      default: h = h0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/ir_beacon_tx_if.sv
// ir_beacon_tx control/status bundle: the controller
// drives master, the beacon transmitter is the slave.
interface ir_beacon_tx_if;
  logic       start;
  logic       stop;
  logic [1:0] freq_sel;
  logic [7:0] burst_cycles;
  logic [7:0] gap_cycles;
  logic       repeat_en;
  logic       tone_out;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, freq_sel,
    output burst_cycles, gap_cycles,
    output repeat_en,
    input  tone_out, busy, done
  );

  modport slave (
    input  start, stop, freq_sel,
    input  burst_cycles, gap_cycles,
    input  repeat_en,
    output tone_out, busy, done
  );
endinterface

// File: rtl/ir_beacon_tx_divider.sv
// Half-period divider: phase is high for the first half of
// each period, period_end fires on the last low-half clock.
module ir_beacon_tx_divider #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] half,
  input  logic             en,
  input  logic             clr,
  output logic             phase,
  output logic             tick,
  output logic             period_end
);
  logic [CNT_W-1:0] hcnt;

  assign tick = en && (hcnt == half - CNT_W'(1));
  assign period_end = tick && !phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt  <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      hcnt  <= '0;
      phase <= 1'b1;
    end else if (en) begin
      if (tick) begin
        hcnt  <= '0;
        phase <= ~phase;
      end else begin
        hcnt <= hcnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: keyed square-wave bursts at one
// of four tones, single-shot or repeating, start/stop control.
module ir_beacon_tx #(
  parameter int HALF0 = ir_beacon_tx_pkg::DEF_HALF0,
  parameter int HALF1 = ir_beacon_tx_pkg::DEF_HALF1,
  parameter int HALF2 = ir_beacon_tx_pkg::DEF_HALF2,
  parameter int HALF3 = ir_beacon_tx_pkg::DEF_HALF3,
  parameter int CNT_W = ir_beacon_tx_pkg::DEF_CNT_W
) (
  input  logic          clock,
  input  logic          reset,
  ir_beacon_tx_if.slave bus
);
  import ir_beacon_tx_pkg::*;

  bcn_state_e       state_q, state_n;
  logic [CNT_W-1:0] half_q;
  logic [7:0]       bl_q, gl_q;
  logic [7:0]       pcnt_q, pcnt_n, pcnt_inc;
  logic             tone_q, tone_n;
  logic             busy_q, done_q, done_n;
  logic             latch, clr, en, seq_end;
  logic             phase, tick, period_end;

  ir_beacon_tx_divider #(.CNT_W(CNT_W)) u_div (
    .clock      (clock),
    .reset      (reset),
    .half       (half_q),
    .en         (en),
    .clr        (clr),
    .phase      (phase),
    .tick       (tick),
    .period_end (period_end)
  );

  assign pcnt_inc = pcnt_q + 8'd1;

  always_comb begin
    state_n = state_q;
    pcnt_n  = pcnt_q;
    done_n  = 1'b0;
    latch   = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    seq_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          latch = 1'b1;
          if (bus.burst_cycles != 8'd0) begin
            state_n = S_TONE;
            clr     = 1'b1;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_TONE: begin
        en = 1'b1;
        if (period_end) begin
          if (pcnt_inc == bl_q) begin
            pcnt_n = 8'd0;
            if (gl_q != 8'd0) state_n = S_GAP;
            else              seq_end = 1'b1;
          end else begin
            pcnt_n = pcnt_inc;
          end
        end
      end
      S_GAP: begin
        en = 1'b1;
        if (period_end) begin
          if (pcnt_inc == gl_q) begin
            pcnt_n  = 8'd0;
            seq_end = 1'b1;
          end else begin
            pcnt_n = pcnt_inc;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    // repeat is sampled live only at the sequence boundary
    if (seq_end) begin
      if (bus.repeat_en) begin
        state_n = S_TONE;
        clr     = 1'b1;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end
    if (bus.stop && state_q != S_IDLE) begin
      state_n = S_IDLE;
      pcnt_n  = 8'd0;
      clr     = 1'b1;
      en      = 1'b0;
      done_n  = 1'b0;
    end
  end

  // Divider phase tracks the tone while in TONE; GAP is silent.
  always_comb begin
    tone_n = 1'b0;
    if (state_n == S_TONE) begin
      if (clr)       tone_n = 1'b1;
      else if (tick) tone_n = ~phase;
      else           tone_n = phase;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      bl_q    <= 8'd0;
      gl_q    <= 8'd0;
      pcnt_q  <= 8'd0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pcnt_q  <= pcnt_n;
      tone_q  <= tone_n;
      busy_q  <= (state_n != S_IDLE);
      done_q  <= done_n;
      if (latch) begin
        half_q <= CNT_W'(half_of(bus.freq_sel,
                                 HALF0, HALF1,
                                 HALF2, HALF3));
        bl_q   <= bus.burst_cycles;
        gl_q   <= bus.gap_cycles;
      end
    end
  end

  assign bus.tone_out = tone_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_ir_beacon_tx.sv
// Self-checking bench for ir_beacon_tx: directed scenarios plus
// random traffic against a time-since-start arithmetic model.
module tb_ir_beacon_tx;
  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int first_hi, done_cyc, done_cnt, busy_cnt, hi_cnt;

  bit m_act  = 1'b0;
  int m_t    = 0;
  int m_h    = 2;
  int m_bl   = 0;
  int m_gl   = 0;
  bit m_tone = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  ir_beacon_tx_if bus();

  ir_beacon_tx #(
    .HALF0(2), .HALF1(3), .HALF2(4), .HALF3(5),
    .CNT_W(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int half_for(input logic [1:0] s);
    case (s)
      2'd0: return 2;
      2'd1: return 3;
      2'd2: return 4;
      default: return 5;
    endcase
  endfunction

  // Sequence position t counts clocks since the tone started;
  // one sequence lasts 2*h*(bl+gl) clocks, tone high in first half
  // of each of the first bl periods.
  task automatic model_edge();
    int p;
    m_done = 1'b0;
    if (!reset) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (m_act) begin
      if (bus.stop) begin
        m_act = 1'b0;
      end else begin
        m_t++;
        if (m_t == 2 * m_h * (m_bl + m_gl)) begin
          if (bus.repeat_en) m_t = 0;
          else begin
            m_act  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end else if (bus.start && !bus.stop) begin
      m_h  = half_for(bus.freq_sel);
      m_bl = int'(bus.burst_cycles);
      m_gl = int'(bus.gap_cycles);
      if (m_bl == 0) m_done = 1'b1;
      else begin
        m_act = 1'b1;
        m_t   = 0;
      end
    end
    p = 2 * m_h;
    m_busy = m_act;
    if (m_act)
      m_tone = (m_t < p * m_bl) && ((m_t % p) < m_h);
    else
      m_tone = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cyc++;
    check("tone", int'(bus.tone_out), int'(m_tone));
    check("busy", int'(bus.busy), int'(m_busy));
    check("done", int'(bus.done), int'(m_done));
    if (bus.tone_out) begin
      hi_cnt++;
      if (first_hi < 0) first_hi = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.busy) busy_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(input logic [1:0] f, input int b,
                        input int g, input bit r);
    bus.freq_sel     = f;
    bus.burst_cycles = 8'(b);
    bus.gap_cycles   = 8'(g);
    bus.repeat_en    = r;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic clr_stats();
    first_hi = -1;
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    hi_cnt   = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_in(2'd0, 0, 0, 1'b0);
    clr_stats();
    run(3);
    reset = 1'b1;
    run(2);

    // single shot
    clr_stats();
    set_in(2'd0, 3, 2, 1'b0);
    pulse_start();
    run(24);
    check("s1_done_dist", done_cyc - first_hi, 20);
    check("s1_done_cnt", done_cnt, 1);
    check("s1_busy_cnt", busy_cnt, 20);
    check("s1_high_cnt", hi_cnt, 6);

    // fastest tone, no gap
    clr_stats();
    set_in(2'd3, 2, 0, 1'b0);
    pulse_start();
    run(24);
    check("s2_done_dist", done_cyc - first_hi, 20);
    check("s2_done_cnt", done_cnt, 1);
    check("s2_high_cnt", hi_cnt, 10);

    // repeat held, then dropped mid-burst
    clr_stats();
    set_in(2'd1, 1, 1, 1'b1);
    pulse_start();
    run(47);
    check("s3_no_done", done_cnt, 0);
    check("s3_high_cnt", hi_cnt, 12);
    run(2);
    bus.repeat_en = 1'b0;
    clr_stats();
    run(15);
    check("s3_end_done", done_cnt, 1);

    // abort five clocks into a burst, restart right after
    clr_stats();
    set_in(2'd0, 3, 2, 1'b0);
    pulse_start();
    run(4);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("s4_tone", int'(bus.tone_out), 0);
    check("s4_busy", int'(bus.busy), 0);
    check("s4_no_done", done_cnt, 0);
    set_in(2'd2, 2, 1, 1'b0);
    pulse_start();
    check("s4_restart", int'(bus.busy), 1);
    run(30);
    check("s4_done_cnt", done_cnt, 1);

    // zero-length burst
    clr_stats();
    set_in(2'd0, 0, 3, 1'b0);
    pulse_start();
    check("s5_zero_done", int'(bus.done), 1);
    check("s5_zero_busy", int'(bus.busy), 0);
    run(3);
    check("s5_zero_high", hi_cnt, 0);
    check("s5_zero_cnt", done_cnt, 1);

    // start while busy is ignored
    clr_stats();
    set_in(2'd0, 2, 1, 1'b0);
    pulse_start();
    run(3);
    set_in(2'd3, 5, 0, 1'b0);
    bus.start = 1'b1;
    run(2);
    bus.start = 1'b0;
    run(20);
    check("s5_busy_dist", done_cyc - first_hi, 12);
    check("s5_busy_high", hi_cnt, 4);
    check("s5_busy_done", done_cnt, 1);

    // stop beats start in IDLE
    set_in(2'd1, 2, 2, 1'b0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("s5_stopstart", int'(bus.busy), 0);
    run(2);

    // async reset mid-tone
    clr_stats();
    set_in(2'd0, 3, 2, 1'b0);
    pulse_start();
    run(4);
    @(posedge clock);
    model_edge();
    #1;
    check("s6_pre_tone", int'(bus.tone_out), int'(m_tone));
    reset = 1'b0;
    #1;
    check("s6_rst_tone", int'(bus.tone_out), 0);
    check("s6_rst_busy", int'(bus.busy), 0);
    check("s6_rst_done", int'(bus.done), 0);
    m_act = 1'b0;
    m_t   = 0;
    @(negedge clock);
    run(3);
    reset = 1'b1;
    clr_stats();
    run(5);
    check("s6_no_done", done_cnt, 0);
    check("s6_idle", busy_cnt, 0);

    // longest burst
    clr_stats();
    set_in(2'd0, 255, 1, 1'b0);
    pulse_start();
    run(1030);
    check("s7_done_dist", done_cyc - first_hi, 1024);
    check("s7_high_cnt", hi_cnt, 510);
    check("s7_done_cnt", done_cnt, 1);

    // random traffic
    bus.repeat_en = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0)
        bus.repeat_en = ~bus.repeat_en;
      bus.freq_sel     = 2'($urandom_range(0, 3));
      bus.burst_cycles = 8'($urandom_range(0, 4));
      bus.gap_cycles   = 8'($urandom_range(0, 3));
      step();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    step();
    bus.stop  = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fails);
    $finish;
  end
endmodule
